// File: rtl/writeback_pipe_if.sv
// Writeback stage bus: instruction fields arriving from the memory stage and the
// registered register-file write command leaving the stage.
interface writeback_pipe_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
);
  logic                    stall;
  logic                    flush;
  logic                    valid_in;
  logic                    opWrite;
  logic [1:0]              opSel;
  logic [REG_SEL_BITS-1:0] opReg;
  logic [2:0]              load_type;
  logic [2:0]              byte_offset;
  logic [DATA_WIDTH-1:0]   ALU_Result;
  logic [DATA_WIDTH-1:0]   memory_data;
  logic [DATA_WIDTH-1:0]   pc_plus4;
  logic                    write;
  logic [REG_SEL_BITS-1:0] write_reg;
  logic [DATA_WIDTH-1:0]   write_data;
  logic                    valid_out;
  logic [31:0]             retired;

  modport master (
    output stall, flush, valid_in, opWrite, opSel, opReg, load_type, byte_offset,
           ALU_Result, memory_data, pc_plus4,
    input  write, write_reg, write_data, valid_out, retired
  );

  modport slave (
    input  stall, flush, valid_in, opWrite, opSel, opReg, load_type, byte_offset,
           ALU_Result, memory_data, pc_plus4,
    output write, write_reg, write_data, valid_out, retired
  );
endinterface

// File: rtl/writeback_pipe.sv
// Registered writeback stage: result select, load lane extraction/extension,
// one-cycle register-file write command with stall/flush, retired-instruction counter.
module writeback_pipe #(
  parameter int CORE         = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int REG_SEL_BITS = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            report,
  writeback_pipe_if.slave wb
);
  localparam int OFF_BITS = (DATA_WIDTH == 64) ? 3 : 2;

  logic [OFF_BITS-1:0]     off_b;
  logic [OFF_BITS-1:0]     off_h;
  logic [5:0]              sh_b;
  logic [5:0]              sh_h;
  logic [5:0]              sh_w;
  logic [DATA_WIDTH-1:0]   lane_b;
  logic [DATA_WIDTH-1:0]   lane_h;
  logic [DATA_WIDTH-1:0]   lane_w;
  logic [DATA_WIDTH-1:0]   load_val;
  logic [DATA_WIDTH-1:0]   result;
  logic                    write_nxt;
  logic                    write_q;
  logic                    valid_q;
  logic [REG_SEL_BITS-1:0] reg_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [31:0]             retired_q;

  // Halfword and word lanes are floor-aligned; the byte lane uses the full offset.
  assign off_b  = wb.byte_offset[OFF_BITS-1:0];
  assign off_h  = {off_b[OFF_BITS-1:1], 1'b0};
  assign sh_b   = 6'(off_b) << 3;
  assign sh_h   = 6'(off_h) << 3;
  assign sh_w   = (DATA_WIDTH == 64) ? {wb.byte_offset[2], 5'b0} : 6'd0;
  assign lane_b = wb.memory_data >> sh_b;
  assign lane_h = wb.memory_data >> sh_h;
  assign lane_w = wb.memory_data >> sh_w;

  always_comb begin
    load_val = wb.memory_data;
    case (wb.load_type)
      3'b000:  load_val = DATA_WIDTH'($signed(lane_b[7:0]));
      3'b001:  load_val = DATA_WIDTH'($signed(lane_h[15:0]));
      3'b010:  load_val = (DATA_WIDTH == 64) ? DATA_WIDTH'($signed(lane_w[31:0])) : wb.memory_data;
      3'b100:  load_val = DATA_WIDTH'(lane_b[7:0]);
      3'b101:  load_val = DATA_WIDTH'(lane_h[15:0]);
      3'b110:  load_val = (DATA_WIDTH == 64) ? DATA_WIDTH'(lane_w[31:0]) : wb.memory_data;
      default: load_val = wb.memory_data;
    endcase
  end

  always_comb begin
    result = wb.ALU_Result;
    case (wb.opSel)
      2'd1:    result = load_val;
      2'd2:    result = wb.pc_plus4;
      default: result = wb.ALU_Result;
    endcase
  end

  // x0 writes are dropped but the instruction still counts as valid and retires.
  assign write_nxt = wb.opWrite & wb.valid_in & (wb.opReg != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else if (wb.flush) begin
      write_q <= 1'b0;
      valid_q <= 1'b0;
      reg_q   <= '0;
      data_q  <= '0;
    end else if (!wb.stall) begin
      write_q <= write_nxt;
      valid_q <= wb.valid_in;
      reg_q   <= wb.opReg;
      data_q  <= result;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
    end else if (wb.valid_in && !wb.flush && !wb.stall) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign wb.write      = write_q;
  assign wb.valid_out  = valid_q;
  assign wb.write_reg  = reg_q;
  assign wb.write_data = data_q;
  assign wb.retired    = retired_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (reset && report && write_nxt && !wb.flush && !wb.stall)
      $display("Core %0d WB x%0d <= %h", CORE, wb.opReg, result);
  end
`endif
endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe: a behavioural model checked every cycle,
// plus literal expectations on selected cycles.
module tb_writeback_pipe;
  logic clock = 1'b0;
  logic reset;
  logic report;

  writeback_pipe_if #(.DATA_WIDTH(32), .REG_SEL_BITS(5)) wbi ();

  writeback_pipe #(.CORE(0), .DATA_WIDTH(32), .REG_SEL_BITS(5)) dut (
    .clock  (clock),
    .reset  (reset),
    .report (report),
    .wb     (wbi)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        m_write, m_valid;
  logic [4:0]  m_reg;
  logic [31:0] m_data, m_retired;
  logic        preset_req;

  logic        lit_en;
  int          lit_sel;
  logic [31:0] lit_val;
  string       lit_name;

  function automatic logic [31:0] load_model(input logic [2:0] lt, input logic [2:0] off,
                                              input logic [31:0] mem);
    int unsigned o;
    int unsigned v;
    o = off % 4;
    case (lt)
      3'b000, 3'b100: begin
        v = (mem >> (8 * o)) % 256;
        if (lt == 3'b000 && v >= 128) v = v + 32'hFFFF_FF00;
      end
      3'b001, 3'b101: begin
        o = o - (o % 2);
        v = (mem >> (8 * o)) % 65536;
        if (lt == 3'b001 && v >= 32768) v = v + 32'hFFFF_0000;
      end
      default: v = mem;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] result_model();
    if (wbi.opSel == 2'd1) return load_model(wbi.load_type, wbi.byte_offset, wbi.memory_data);
    if (wbi.opSel == 2'd2) return wbi.pc_plus4;
    return wbi.ALU_Result;
  endfunction

  always @(posedge clock or negedge reset or posedge preset_req) begin
    if (!reset) begin
      m_write   <= 1'b0;
      m_valid   <= 1'b0;
      m_reg     <= '0;
      m_data    <= '0;
      m_retired <= '0;
    end else if (preset_req) begin
      m_retired <= 32'hFFFF_FFFF;
    end else begin
      if (wbi.flush) begin
        m_write <= 1'b0;
        m_valid <= 1'b0;
        m_reg   <= '0;
        m_data  <= '0;
      end else if (!wbi.stall) begin
        m_valid <= wbi.valid_in;
        m_write <= wbi.valid_in && wbi.opWrite && (wbi.opReg != 5'd0);
        m_reg   <= wbi.opReg;
        m_data  <= result_model();
      end
      if (wbi.valid_in && !wbi.flush && !wbi.stall) m_retired <= m_retired + 32'd1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) #1;
      chk("write",      32'(wbi.write),     32'(m_write));
      chk("valid_out",  32'(wbi.valid_out), 32'(m_valid));
      chk("write_reg",  32'(wbi.write_reg), 32'(m_reg));
      chk("write_data", wbi.write_data,     m_data);
      chk("retired",    wbi.retired,        m_retired);
      if (lit_en) begin
        case (lit_sel)
          0:       chk(lit_name, wbi.write_data,     lit_val);
          1:       chk(lit_name, 32'(wbi.write),     lit_val);
          2:       chk(lit_name, 32'(wbi.valid_out), lit_val);
          3:       chk(lit_name, wbi.retired,        lit_val);
          default: chk(lit_name, 32'(wbi.write_reg), lit_val);
        endcase
      end
    end
  end

  task automatic drive(input logic v, input logic w, input logic [1:0] sel, input logic [4:0] r,
                       input logic [2:0] lt, input logic [2:0] off, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc,
                       input logic st, input logic fl);
    @(negedge clock);
    #1;
    lit_en          = 1'b0;
    wbi.valid_in    = v;
    wbi.opWrite     = w;
    wbi.opSel       = sel;
    wbi.opReg       = r;
    wbi.load_type   = lt;
    wbi.byte_offset = off;
    wbi.ALU_Result  = alu;
    wbi.memory_data = mem;
    wbi.pc_plus4    = pc;
    wbi.stall       = st;
    wbi.flush       = fl;
  endtask

  task automatic expect_lit(input int sel, input logic [31:0] val, input string name);
    lit_en   = 1'b1;
    lit_sel  = sel;
    lit_val  = val;
    lit_name = name;
  endtask

  localparam logic [31:0] MEM = 32'h80F1_7F02;

  initial begin
    reset      = 1'b0;
    report     = 1'b1;
    preset_req = 1'b0;
    lit_en     = 1'b0;
    lit_sel    = 0;
    lit_val    = '0;
    lit_name   = "";
    wbi.valid_in = 0; wbi.opWrite = 0; wbi.opSel = 0; wbi.opReg = 0;
    wbi.load_type = 0; wbi.byte_offset = 0; wbi.ALU_Result = 0;
    wbi.memory_data = 0; wbi.pc_plus4 = 0; wbi.stall = 0; wbi.flush = 0;

    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #1 reset = 1'b1;

    drive(1, 1, 0, 3, 0, 0, 32'd5, 0, 0, 0, 0);        expect_lit(3, 32'd1, "alu_retired");
    drive(1, 1, 1, 5, 3'b000, 3, 0, MEM, 0, 0, 0);     expect_lit(0, 32'hFFFF_FF80, "lb_off3");
    drive(1, 1, 1, 5, 3'b100, 3, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h0000_0080, "lbu_off3");
    drive(1, 1, 1, 5, 3'b001, 2, 0, MEM, 0, 0, 0);     expect_lit(0, 32'hFFFF_80F1, "lh_off2");
    drive(1, 1, 1, 5, 3'b101, 3, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h0000_80F1, "lhu_off3");
    drive(1, 1, 1, 5, 3'b010, 1, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h80F1_7F02, "lw_off1");
    drive(1, 1, 1, 5, 3'b100, 7, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h0000_0080, "lbu_off7");
    drive(1, 1, 1, 5, 3'b000, 1, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h0000_007F, "lb_off1");
    drive(1, 1, 1, 5, 3'b001, 1, 0, MEM, 0, 0, 0);     expect_lit(0, 32'h0000_7F02, "lh_off1");
    drive(1, 1, 1, 5, 3'b110, 2, 0, MEM, 0, 0, 0);     expect_lit(0, MEM, "lwu_code");
    drive(1, 1, 1, 5, 3'b111, 3, 0, MEM, 0, 0, 0);     expect_lit(0, MEM, "raw_code");
    drive(1, 1, 0, 0, 0, 0, 32'd7, 0, 0, 0, 0);        expect_lit(1, 32'd0, "x0_write");
    drive(1, 1, 0, 0, 0, 0, 32'd7, 0, 0, 0, 0);        expect_lit(3, 32'd13, "x0_retired");
    drive(1, 1, 2, 1, 0, 0, 32'h55, 0, 32'h104, 0, 0); expect_lit(0, 32'h104, "link_data");
    drive(1, 1, 3, 2, 0, 0, 32'hABCD, MEM, 32'h8, 0, 0); expect_lit(0, 32'hABCD, "sel3_alu");
    drive(1, 0, 0, 6, 0, 0, 32'd1, 0, 0, 0, 0);        expect_lit(1, 32'd0, "no_opwrite");
    drive(0, 1, 0, 7, 0, 0, 32'h77, 0, 0, 0, 0);       expect_lit(4, 32'd7, "invalid_reg_loads");

    drive(1, 1, 0, 4, 0, 0, 32'd9, 0, 0, 0, 0);
    drive(1, 1, 0, 8, 0, 0, 32'h33, 0, 0, 1, 0);
    drive(1, 1, 1, 9, 3'b000, 3, 32'h44, MEM, 0, 1, 0);
    drive(0, 0, 2, 10, 0, 0, 32'h66, 0, 32'h200, 1, 0); expect_lit(0, 32'd9, "stall_hold");
    drive(1, 1, 0, 9, 0, 0, 32'd1, 0, 0, 1, 1);        expect_lit(2, 32'd0, "flush_over_stall");
    drive(1, 1, 0, 10, 0, 0, 32'h1234, 0, 0, 0, 0);
    drive(1, 1, 0, 11, 0, 0, 32'h5, 0, 0, 0, 1);       expect_lit(1, 32'd0, "flush_only");

    drive(1, 1, 0, 12, 0, 0, 32'hCAFE, 0, 0, 0, 0);
    drive(1, 1, 0, 13, 0, 0, 32'hBEEF, 0, 0, 1, 0);
    @(negedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    force dut.retired_q = 32'hFFFF_FFFF;
    preset_req = 1'b1;
    #1;
    release dut.retired_q;
    preset_req = 1'b0;
    drive(1, 1, 0, 14, 0, 0, 32'd1, 0, 0, 0, 0);       expect_lit(3, 32'd0, "retired_wrap");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

Registered, parametrised writeback stage for BRISC-V pipelined cores. It selects the result source (ALU, memory load, or link address) and performs RISC-V load byte/half/word extraction with sign or zero extension. It registers the register-file write command for one cycle with stall and flush control, and counts retired instructions. It sits between the memory stage and the register file, and its registered outputs also feed the decode-stage bypass network.

## Interface
- CORE, 0: core index, used only in simulation report messages.
- DATA_WIDTH, 32: datapath width; legal values are 32 and 64.
- REG_SEL_BITS, 5: register index width.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold the output register contents.
- flush  input  1  discard the entry being captured and clear the outputs.
- valid_in  input  1  the incoming instruction is valid.
- opWrite  input  1  the instruction writes a destination register.
- opSel  input  2  result source: 0 = ALU, 1 = load data, 2 = pc_plus4, 3 = ALU.
- opReg  input  REG_SEL_BITS  destination register index.
- load_type  input  3  funct3 of the load.
- byte_offset  input  3  low address bits of the load; bit 2 is ignored when DATA_WIDTH=32.
- ALU_Result  input  DATA_WIDTH  ALU result.
- memory_data  input  DATA_WIDTH  raw aligned memory word.
- pc_plus4  input  DATA_WIDTH  link value for JAL/JALR.
- report  input  1  when high, print each write with $display; simulation only.
- write  output  1  register-file write enable.
- write_reg  output  REG_SEL_BITS  destination index.
- write_data  output  DATA_WIDTH  write value.
- valid_out  output  1  the registered entry is valid.
- retired  output  32  count of retired instructions.

## Operation
- The next write is computed combinationally as opWrite & valid_in & (opReg != 0). Writes to x0 are suppressed, but the instruction is still valid and still retires.
- Load extraction applies only when opSel=1. The extracted lane is memory_data shifted right by 8×byte_offset.
  - LB (000): sign-extend the byte.
  - LH (001): sign-extend the halfword; byte_offset[0] is ignored (floor alignment).
  - LW (010): the full word when DATA_WIDTH=32; sign-extend the word when DATA_WIDTH=64, with offset bits [1:0] ignored.
  - LD (011): full DATA_WIDTH.
  - LBU (100): zero-extend the byte.
  - LHU (101): zero-extend the halfword.
  - LWU (110): zero-extend the word.
  - 111: full DATA_WIDTH, unmodified.
- When DATA_WIDTH=32, codes 011, 110 and 111 all pass memory_data unmodified.
- Register update priority per rising clock edge:
  - flush: write, valid_out, write_reg and write_data are cleared to 0.
  - else stall: all outputs hold their values.
  - else: write, write_reg, write_data and valid_out load the computed values. When valid_in=0, valid_out and write become 0; write_reg and write_data still load.
- retired increments by 1 on every edge where valid_in=1, flush=0 and stall=0. It wraps from 0xFFFFFFFF to 0. It is unaffected by flush and stall otherwise.
- When report=1 and a write is captured, print "Core CORE WB x<reg> <= <data>".

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- Each output is driven directly from a register; there is no combinational input-to-output path.
- Asserting reset (low) immediately and asynchronously clears write, write_reg, write_data, valid_out and retired to 0. This holds even mid-stall. Outputs stay 0 until the first edge after reset is released.
- flush together with stall: flush wins, and the outputs clear on that edge.
- A stall longer than one cycle holds the entry indefinitely, and write stays asserted if it was set. The register file must tolerate a repeated identical write.
- An instruction presented while stall=1 is not captured. The upstream stage must hold it.

## Test plan
- ALU path: valid_in=1, opWrite=1, opSel=0, opReg=3, ALU_Result=5 → on the next cycle write=1, write_reg=3, write_data=5, valid_out=1, retired=1.
- Loads: memory_data=0x80F1_7F02.
  - LB with offset 3 → write_data=0xFFFFFF80.
  - LBU with offset 3 → 0x00000080.
  - LH with offset 2 → 0xFFFF80F1.
  - LHU with offset 3 → 0x000080F1.
- x0 and link: opReg=0, opWrite=1 → write=0, valid_out=1, retired increments. opSel=2, pc_plus4=0x104, opReg=1 → write_data=0x104.
- Stall/flush: capture ALU_Result=9 to x4, then hold stall for 3 cycles while the inputs change → outputs stay x4/9 and retired is unchanged. Assert flush together with stall → write=0 and valid_out=0 on the next cycle.
- Reset: drive reset low asynchronously between edges while write=1 → all outputs read 0 before the next edge. Force retired to 0xFFFFFFFF, then retire one instruction → retired=0.
